// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso serializer.
//
// Contents:
//   piso_state_t   - FSM state encoding (IDLE, SHIFT)
//   PARITY_EN      - 1 when the build defines PISO_PARITY_EN
//   piso_cnt_width - bit-count register width for a given word width
//   piso_frame     - serial frame length in bits (data bits plus optional parity bit)
//
// Build option: PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

`ifdef PISO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // The range reserves headroom above the largest frame index, so the count
    // never needs to wrap.
    function automatic int unsigned piso_cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    function automatic int unsigned piso_frame(input int unsigned width);
        return PARITY_EN ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out serializer feeding the downstream SIPO.
//
// A WIDTH-bit word is accepted over a valid/ready handshake. It is then sent
// one bit per accepted beat on a serial valid/ready link. MSB_FIRST selects
// whether bit WIDTH-1 or bit 0 goes out first.
//
// Parameters:
//   WIDTH      parallel word width (>= 2)
//   MSB_FIRST  1: send bit WIDTH-1 first, 0: send bit 0 first
//
// Ports:
//   clk_in     clock, rising edge
//   rst        asynchronous reset, active-high
//   data_in    parallel word, sampled on accept
//   valid_in   upstream word valid
//   ready_out  block can accept a word (low while rst is high)
//   data_out   serial bit
//   valid_out  data_out valid
//   ready_in   downstream accepts the current bit
//   last_out   current bit is the final bit of the frame
//
// Build option: PISO_PARITY_EN
//   When this macro is defined, an even-parity bit (^word) follows the data
//   bits, and last_out marks that parity bit. When it is undefined, the
//   parity register does not exist.
//
// State table:
//   state | meaning
//   IDLE  | waiting for a word, ready_out high
//   SHIFT | presenting bits, valid_out high
module piso
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             last_out
);

    localparam int unsigned CW    = piso_cnt_width(WIDTH);
    localparam int unsigned FRAME = piso_frame(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             head_bit;
    logic             accept;
    logic             xfer;

`ifdef PISO_PARITY_EN
    logic parity_q, parity_d;
`endif

    assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    assign ready_out = (state_q == IDLE) & ~rst;
    assign valid_out = (state_q == SHIFT);
    assign last_out  = valid_out & (cnt_q == LAST_CNT);

`ifdef PISO_PARITY_EN
    // By the time the count reaches WIDTH, all data bits have been shifted
    // out, so the registered parity bit takes the head position.
    assign data_out = (cnt_q == CW'(WIDTH)) ? parity_q : head_bit;
`else
    assign data_out = head_bit;
`endif

    assign accept = valid_in & ready_out;
    assign xfer   = valid_out & ready_in;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (cnt_q == LAST_CNT) begin
                        // Clearing the register on the way out keeps data_out
                        // at 0 while the block is idle.
                        state_d = IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end else begin
                        shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg_q[WIDTH-1:1]};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule
